nebula_core_l2_arb: RTL and testbench
=====================================

Name: nebula_core_l2_arb

Overview:
Per-core front-end arbiter between a Nebula core's three memory masters (L1 I-cache refill, L1 D-cache refill/writeback/AMO, page-table walker) and that core's single port into the shared L2 cache.
- Grants one source at a time.
- Registers and holds the request fields until L2 accepts them.
- Tracks the single outstanding transaction and routes the response back to the source that issued it.
- Extracts the 64-bit PTE word for the walker.
- Prevents starvation of the lower-priority sources.

Parameters:
CORE_ID, 0, value driven on l2_req_core_id
CORE_ID_W, 2, width of core id field
PADDR_WIDTH, 56, physical address width
LINE_BITS, 512, cache line width in bits
XLEN, 64, PTE word width
STARVE_LIMIT, 8, lost arbitrations before a waiting source is promoted (range 1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset
imem_req  in  1  I-side request, level, held until imem_ack
imem_addr  in  PADDR_WIDTH  I-side line address
imem_ack  out  1  one-cycle completion pulse
imem_data  out  LINE_BITS  refill line, valid with imem_ack
dmem_req  in  1  D-side request, level, held until dmem_ack
dmem_we  in  1  writeback
dmem_addr  in  PADDR_WIDTH  D-side address
dmem_wdata  in  LINE_BITS  writeback line
dmem_is_amo  in  1  atomic operation
dmem_amo_op  in  5  AMO opcode
dmem_upgrade  in  1  S->M upgrade request
dmem_ack  out  1  one-cycle completion pulse
dmem_rdata  out  LINE_BITS  read line, valid with dmem_ack
ptw_req  in  1  walker request, level, held until ptw_ack
ptw_addr  in  PADDR_WIDTH  PTE byte address
ptw_ack  out  1  one-cycle completion pulse
ptw_data  out  XLEN  PTE word, valid with ptw_ack
src_error  out  1  asserted with any ack when L2 reported an error
l2_req_valid  out  1  request to L2
l2_req_ready  in  1  L2 accepts when valid && ready
l2_req_core_id  out  CORE_ID_W  constant CORE_ID
l2_req_is_ifetch  out  1  granted source is I-side
l2_req_is_write, l2_req_is_amo, l2_req_upgrade  out  1 each  copied from D-side, 0 otherwise
l2_req_amo_op  out  5  copied from D-side, 0 otherwise
l2_req_addr  out  PADDR_WIDTH  granted address
l2_req_wdata  out  LINE_BITS  D-side wdata, 0 otherwise
l2_resp_valid  in  1  one-cycle response pulse
l2_resp_rdata  in  LINE_BITS  response line
l2_resp_error  in  1  response error
spurious_resp  out  1  sticky; set on l2_resp_valid outside WAIT

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: FSM in IDLE. All outputs 0, except l2_req_core_id, which is CORE_ID. Starvation counters are 0. Latched fields are 0. Reset mid-transaction abandons the transaction and generates no ack.
- FSM transitions:
  - IDLE: if any request is high, register the granted source and all its fields, then go to REQ. Otherwise stay in IDLE.
  - REQ: l2_req_valid=1 with stable registered fields. On l2_req_ready, go to WAIT.
  - WAIT: on l2_resp_valid, register rdata and error, then go to RESP.
  - RESP: pulse exactly one of imem_ack, dmem_ack or ptw_ack for one cycle, with src_error=l2_resp_error. Data outputs hold the registered line or word. Then go to IDLE.
- Request fields: inputs are sampled only at grant. Later changes to a source's inputs have no effect on the transaction in flight.
- Response routing: uses the latched source only, never l2_resp_rdata or is_ifetch.
- PTE extraction: ptw_data = rdata[64*k +: 64], where k = latched ptw_addr[5:3].
- Latency: request high in IDLE at cycle N gives l2_req_valid at N+1. l2_resp_valid at cycle M gives the ack at M+1. Minimum request-to-ack latency is 3 cycles (ready at N+1, response at N+2).
- Priority: D > I > PTW.
- Starvation counters:
  - I and PTW each have a counter that increments when that source is requesting in IDLE but loses the grant. It saturates at STARVE_LIMIT.
  - A counter clears when its source is granted.
  - A counter at STARVE_LIMIT promotes its source above D.
  - If both counters are at the limit, PTW wins.
  - The D-side has no counter.
- Data outputs: data outputs not being acked hold their last values. Acks are never asserted in IDLE, REQ or WAIT.
- Response outside WAIT: l2_resp_valid in IDLE, REQ or RESP is ignored and sets spurious_resp, which clears only on reset.

Test Plan:
1. Single I request, addr 0x8000_0040, ready same cycle, response rdata=pattern one cycle later → l2_req_is_ifetch=1, imem_ack exactly 3 cycles after imem_req, imem_data=pattern, no other ack.
2. dmem_req, imem_req and ptw_req raised together, all held → grant order D, I, PTW. Each ack follows the previous ack's IDLE cycle, and l2 fields match each source.
3. ptw_addr=0x1000_0028 with response line words w0..w7 → ptw_data=w5. ptw_addr low bits 0x38 → ptw_data=w7.
4. dmem_req re-raised continuously while imem_req held, STARVE_LIMIT=8 → I granted on its 9th arbitration. The I counter then reads 0, and D resumes priority.
5. l2_req_ready held low 20 cycles while dmem_addr and dmem_wdata change → l2_req_* stable the whole time. Acceptance occurs on the cycle ready rises.
6. rst_n asserted in WAIT, then l2_resp_valid after release → no ack, FSM in IDLE, spurious_resp=1. l2_resp_error=1 on a normal D transaction → dmem_ack with src_error=1.

Source files
------------

// File: rtl/nebula_core_l2_arb.sv
// Per-core arbiter between the I-cache, D-cache and page-table walker and the
// core's single L2 port. Handles one transaction at a time: grant, hold the
// request until accepted, wait for the response, then ack the issuing source.
module nebula_core_l2_arb #(
   parameter int CORE_ID      = 0,
   parameter int CORE_ID_W    = 2,
   parameter int PADDR_WIDTH  = 56,
   parameter int LINE_BITS    = 512,
   parameter int XLEN         = 64,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   imem_req,
   input  logic [PADDR_WIDTH-1:0] imem_addr,
   output logic                   imem_ack,
   output logic [LINE_BITS-1:0]   imem_data,
   input  logic                   dmem_req,
   input  logic                   dmem_we,
   input  logic [PADDR_WIDTH-1:0] dmem_addr,
   input  logic [LINE_BITS-1:0]   dmem_wdata,
   input  logic                   dmem_is_amo,
   input  logic [4:0]             dmem_amo_op,
   input  logic                   dmem_upgrade,
   output logic                   dmem_ack,
   output logic [LINE_BITS-1:0]   dmem_rdata,
   input  logic                   ptw_req,
   input  logic [PADDR_WIDTH-1:0] ptw_addr,
   output logic                   ptw_ack,
   output logic [XLEN-1:0]        ptw_data,
   output logic                   src_error,
   output logic                   l2_req_valid,
   input  logic                   l2_req_ready,
   output logic [CORE_ID_W-1:0]   l2_req_core_id,
   output logic                   l2_req_is_ifetch,
   output logic                   l2_req_is_write,
   output logic                   l2_req_is_amo,
   output logic                   l2_req_upgrade,
   output logic [4:0]             l2_req_amo_op,
   output logic [PADDR_WIDTH-1:0] l2_req_addr,
   output logic [LINE_BITS-1:0]   l2_req_wdata,
   input  logic                   l2_resp_valid,
   input  logic [LINE_BITS-1:0]   l2_resp_rdata,
   input  logic                   l2_resp_error,
   output logic                   spurious_resp
);

   localparam int WORDS = LINE_BITS / XLEN;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   typedef enum logic [1:0] {SRC_I, SRC_D, SRC_P} src_t;

   state_t                 state_reg, state_next;
   src_t                   src_reg, grant_src;
   logic [PADDR_WIDTH-1:0] addr_reg;
   logic [LINE_BITS-1:0]   wdata_reg;
   logic                   we_reg, amo_reg, upgrade_reg, err_reg, spurious_reg;
   logic [4:0]             amo_op_reg;
   logic [LINE_BITS-1:0]   idata_reg, ddata_reg;
   logic [XLEN-1:0]        pdata_reg;
   logic [7:0]             cnt_i_reg, cnt_p_reg;
   logic                   any_req, grant_en, resp_take;
   logic [XLEN-1:0]        pte_words [WORDS];
   logic [IDX_W-1:0]       word_idx;

   assign any_req   = imem_req | dmem_req | ptw_req;
   assign grant_en  = (state_reg == IDLE) && any_req;
   assign resp_take = (state_reg == WAIT) && l2_resp_valid;
   assign word_idx  = addr_reg[OFF_W +: IDX_W];

   // Split the response line into PTE-sized words for the walker.
   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_pte
         assign pte_words[gi] = l2_resp_rdata[gi*XLEN +: XLEN];
      end
   endgenerate

   // Priority: a starved source (PTW first) beats D, otherwise D > I > PTW.
   always_comb begin
      grant_src = SRC_D;
      if (ptw_req && cnt_p_reg == LIMIT)
         grant_src = SRC_P;
      else if (imem_req && cnt_i_reg == LIMIT)
         grant_src = SRC_I;
      else if (dmem_req)
         grant_src = SRC_D;
      else if (imem_req)
         grant_src = SRC_I;
      else if (ptw_req)
         grant_src = SRC_P;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic: IDLE -> REQ -> WAIT -> RESP -> IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (any_req)       state_next = REQ;
         REQ:     if (l2_req_ready)  state_next = WAIT;
         WAIT:    if (l2_resp_valid) state_next = RESP;
         RESP:                       state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // Latch the granted source's request fields; they stay frozen until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_reg     <= SRC_I;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         we_reg      <= 1'b0;
         amo_reg     <= 1'b0;
         upgrade_reg <= 1'b0;
         amo_op_reg  <= '0;
      end else if (grant_en) begin
         src_reg     <= grant_src;
         we_reg      <= 1'b0;
         amo_reg     <= 1'b0;
         upgrade_reg <= 1'b0;
         amo_op_reg  <= '0;
         wdata_reg   <= '0;
         case (grant_src)
            SRC_I:   addr_reg <= imem_addr;
            SRC_P:   addr_reg <= ptw_addr;
            default: begin
               addr_reg    <= dmem_addr;
               wdata_reg   <= dmem_wdata;
               we_reg      <= dmem_we;
               amo_reg     <= dmem_is_amo;
               upgrade_reg <= dmem_upgrade;
               amo_op_reg  <= dmem_amo_op;
            end
         endcase
      end
   end

   // Capture the response into the issuing source's data register only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg   <= 1'b0;
         idata_reg <= '0;
         ddata_reg <= '0;
         pdata_reg <= '0;
      end else if (resp_take) begin
         err_reg <= l2_resp_error;
         case (src_reg)
            SRC_I:   idata_reg <= l2_resp_rdata;
            SRC_D:   ddata_reg <= l2_resp_rdata;
            default: pdata_reg <= pte_words[word_idx];
         endcase
      end
   end

   // Starvation counters: count lost arbitrations, clear on grant, saturate at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_i_reg <= '0;
         cnt_p_reg <= '0;
      end else if (grant_en) begin
         if (grant_src == SRC_I)
            cnt_i_reg <= '0;
         else if (imem_req && cnt_i_reg != LIMIT)
            cnt_i_reg <= cnt_i_reg + 8'd1;
         if (grant_src == SRC_P)
            cnt_p_reg <= '0;
         else if (ptw_req && cnt_p_reg != LIMIT)
            cnt_p_reg <= cnt_p_reg + 8'd1;
      end
   end

   // Sticky flag for responses that arrive when none is expected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    spurious_reg <= 1'b0;
      else if (l2_resp_valid && state_reg != WAIT)   spurious_reg <= 1'b1;
   end

   assign l2_req_valid     = (state_reg == REQ);
   assign l2_req_core_id   = CORE_ID_W'(CORE_ID);
   assign l2_req_is_ifetch = (state_reg != IDLE) && (src_reg == SRC_I) ? 1'b1 : 1'b0;
   assign l2_req_is_write  = we_reg;
   assign l2_req_is_amo    = amo_reg;
   assign l2_req_upgrade   = upgrade_reg;
   assign l2_req_amo_op    = amo_op_reg;
   assign l2_req_addr      = addr_reg;
   assign l2_req_wdata     = wdata_reg;
   assign imem_ack         = (state_reg == RESP) && (src_reg == SRC_I);
   assign dmem_ack         = (state_reg == RESP) && (src_reg == SRC_D);
   assign ptw_ack          = (state_reg == RESP) && (src_reg == SRC_P);
   assign src_error        = (state_reg == RESP) && err_reg;
   assign imem_data        = idata_reg;
   assign dmem_rdata       = ddata_reg;
   assign ptw_data         = pdata_reg;
   assign spurious_resp    = spurious_reg;

endmodule

// File: tb/tb_nebula_core_l2_arb.sv
// Randomized self-checking bench for nebula_core_l2_arb with a behavioural
// arbitration/data model; one task per scenario.
module tb_nebula_core_l2_arb;

   localparam int LIMIT = 8;
   localparam logic [1:0] CID = 2'd0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic imem_req = 0, dmem_req = 0, ptw_req = 0;
   logic [55:0] imem_addr = '0, dmem_addr = '0, ptw_addr = '0;
   logic dmem_we = 0, dmem_is_amo = 0, dmem_upgrade = 0;
   logic [4:0] dmem_amo_op = '0;
   logic [511:0] dmem_wdata = '0;
   logic l2_req_ready = 0, l2_resp_valid = 0, l2_resp_error = 0;
   logic [511:0] l2_resp_rdata = '0;

   logic imem_ack, dmem_ack, ptw_ack, src_error, l2_req_valid, spurious_resp;
   logic [511:0] imem_data, dmem_rdata, l2_req_wdata;
   logic [63:0] ptw_data;
   logic [1:0] l2_req_core_id;
   logic l2_req_is_ifetch, l2_req_is_write, l2_req_is_amo, l2_req_upgrade;
   logic [4:0] l2_req_amo_op;
   logic [55:0] l2_req_addr;

   int n_checks = 0;
   int n_fail = 0;
   int n_txn = 0;

   // Behavioural model state.
   int cnt_i_m = 0, cnt_p_m = 0;
   logic [511:0] exp_idata = '0, exp_ddata = '0;
   logic [63:0] exp_pdata = '0;

   typedef struct {
      int timeout; int wait_cycles; int lat;
      logic stable; logic valid_after; logic early; logic ack_after;
      logic [578:0] fields; logic [2:0] acks; logic err;
      logic [511:0] idata; logic [511:0] ddata; logic [63:0] pdata;
   } obs_t;

   always #5 clk = ~clk;

   nebula_core_l2_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_is_amo(dmem_is_amo), .dmem_amo_op(dmem_amo_op), .dmem_upgrade(dmem_upgrade),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .ptw_req(ptw_req), .ptw_addr(ptw_addr), .ptw_ack(ptw_ack), .ptw_data(ptw_data),
      .src_error(src_error), .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
      .l2_req_core_id(l2_req_core_id), .l2_req_is_ifetch(l2_req_is_ifetch),
      .l2_req_is_write(l2_req_is_write), .l2_req_is_amo(l2_req_is_amo),
      .l2_req_upgrade(l2_req_upgrade), .l2_req_amo_op(l2_req_amo_op),
      .l2_req_addr(l2_req_addr), .l2_req_wdata(l2_req_wdata),
      .l2_resp_valid(l2_resp_valid), .l2_resp_rdata(l2_resp_rdata),
      .l2_resp_error(l2_resp_error), .spurious_resp(spurious_resp)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   function automatic logic [55:0] rand_addr();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[55:0];
   endfunction

   // Source ids: 0 = I, 1 = D, 2 = PTW.
   function automatic int model_pick(bit i, bit d, bit p);
      if (p && cnt_p_m >= LIMIT) return 2;
      if (i && cnt_i_m >= LIMIT) return 0;
      if (d) return 1;
      if (i) return 0;
      if (p) return 2;
      return -1;
   endfunction

   function automatic void model_commit(bit i, bit p, int g);
      if (g == 0) cnt_i_m = 0;
      else if (i) cnt_i_m = (cnt_i_m + 1 > LIMIT) ? LIMIT : cnt_i_m + 1;
      if (g == 2) cnt_p_m = 0;
      else if (p) cnt_p_m = (cnt_p_m + 1 > LIMIT) ? LIMIT : cnt_p_m + 1;
   endfunction

   function automatic logic [63:0] pte_of(logic [511:0] line, logic [55:0] a);
      logic [511:0] sh;
      sh = line >> (64 * int'(a[5:3]));
      return sh[63:0];
   endfunction

   function automatic void model_ack(int s, logic [511:0] line);
      if (s == 0) exp_idata = line;
      else if (s == 1) exp_ddata = line;
      else exp_pdata = pte_of(line, ptw_addr);
   endfunction

   function automatic logic [578:0] exp_fields(int s);
      if (s == 0) return {CID, 4'b1000, 5'd0, imem_addr, 512'd0};
      if (s == 1) return {CID, 1'b0, dmem_we, dmem_is_amo, dmem_upgrade, dmem_amo_op, dmem_addr, dmem_wdata};
      return {CID, 4'b0000, 5'd0, ptw_addr, 512'd0};
   endfunction

   // Plays the L2 side of one transaction and records what the DUT did.
   task automatic do_l2(input int rdly, input int pdly, input logic [511:0] rd,
                        input logic er, input bit scramble, output obs_t o);
      int n;
      o = '{default: 0};
      n = 0;
      o.stable = 1'b1;
      while (!l2_req_valid && n < 50) begin
         step();
         n++;
      end
      o.wait_cycles = n;
      if (!l2_req_valid) begin
         o.timeout = 1;
         return;
      end
      o.fields = {l2_req_core_id, l2_req_is_ifetch, l2_req_is_write, l2_req_is_amo,
                  l2_req_upgrade, l2_req_amo_op, l2_req_addr, l2_req_wdata};
      for (int i = 0; i < rdly; i++) begin
         if (scramble) begin
            dmem_addr  = rand_addr();
            dmem_wdata = rand_line();
         end
         step();
         n++;
         if (!l2_req_valid || o.fields != {l2_req_core_id, l2_req_is_ifetch, l2_req_is_write,
             l2_req_is_amo, l2_req_upgrade, l2_req_amo_op, l2_req_addr, l2_req_wdata})
            o.stable = 1'b0;
         if (imem_ack | dmem_ack | ptw_ack) o.early = 1'b1;
      end
      l2_req_ready = 1'b1;
      step();
      n++;
      l2_req_ready = 1'b0;
      o.valid_after = l2_req_valid;
      if (imem_ack | dmem_ack | ptw_ack) o.early = 1'b1;
      for (int i = 0; i < pdly; i++) begin
         step();
         n++;
         if (imem_ack | dmem_ack | ptw_ack) o.early = 1'b1;
      end
      l2_resp_valid = 1'b1;
      l2_resp_rdata = rd;
      l2_resp_error = er;
      step();
      n++;
      l2_resp_valid = 1'b0;
      l2_resp_error = 1'b0;
      o.lat   = n;
      o.acks  = {ptw_ack, dmem_ack, imem_ack};
      o.err   = src_error;
      o.idata = imem_data;
      o.ddata = dmem_rdata;
      o.pdata = ptw_data;
      if (imem_ack) imem_req = 1'b0;
      if (dmem_ack) dmem_req = 1'b0;
      if (ptw_ack)  ptw_req  = 1'b0;
      step();
      o.ack_after = imem_ack | dmem_ack | ptw_ack;
      n_txn++;
      $display("txn %0d: acks=%b err=%b lat=%0d addr=%h", n_txn, o.acks, o.err, o.lat, o.fields[567:512]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_checks++; if ({imem_ack, dmem_ack, ptw_ack, src_error} !== 4'b0) begin n_fail++; $display("FAIL reset_acks: got %b expected 0000", {imem_ack, dmem_ack, ptw_ack, src_error}); end
      n_checks++; if (l2_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", l2_req_valid); end
      n_checks++; if ({l2_req_is_ifetch, l2_req_is_write, l2_req_is_amo, l2_req_upgrade, l2_req_amo_op} !== 9'b0) begin n_fail++; $display("FAIL reset_flags: got %h expected 0", {l2_req_is_ifetch, l2_req_is_write, l2_req_is_amo, l2_req_upgrade, l2_req_amo_op}); end
      n_checks++; if (l2_req_addr !== 56'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", l2_req_addr); end
      n_checks++; if (l2_req_wdata !== 512'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", l2_req_wdata); end
      n_checks++; if ({imem_data, dmem_rdata, ptw_data} !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero data outputs expected 0"); end
      n_checks++; if (spurious_resp !== 1'b0) begin n_fail++; $display("FAIL reset_spurious: got %b expected 0", spurious_resp); end
      n_checks++; if (l2_req_core_id !== CID) begin n_fail++; $display("FAIL reset_core_id: got %h expected %h", l2_req_core_id, CID); end
      rst_n = 1'b1;
      step();
      step();
      n_checks++; if (l2_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b expected 0", l2_req_valid); end
   endtask

   task automatic test_single_ifetch();
      obs_t o;
      logic [511:0] rd;
      logic [578:0] ef;
      int s;
      imem_addr = 56'h8000_0040;
      imem_req  = 1'b1;
      rd = rand_line();
      s = model_pick(1, 0, 0);
      ef = exp_fields(s);
      model_commit(1, 0, s);
      model_ack(s, rd);
      do_l2(0, 0, rd, 1'b0, 1'b0, o);
      n_checks++; if (o.timeout !== 0) begin n_fail++; $display("FAIL ifetch_timeout: got %0d expected 0", o.timeout); end
      n_checks++; if (o.fields !== ef) begin n_fail++; $display("FAIL ifetch_fields: got %h expected %h", o.fields, ef); end
      n_checks++; if (o.lat !== 3) begin n_fail++; $display("FAIL ifetch_latency: got %0d expected 3", o.lat); end
      n_checks++; if (o.acks !== 3'b001) begin n_fail++; $display("FAIL ifetch_acks: got %b expected 001", o.acks); end
      n_checks++; if (o.idata !== rd) begin n_fail++; $display("FAIL ifetch_data: got %h expected %h", o.idata, rd); end
      n_checks++; if ({o.err, o.early, o.ack_after} !== 3'b000) begin n_fail++; $display("FAIL ifetch_pulse: got %b expected 000", {o.err, o.early, o.ack_after}); end
   endtask

   task automatic test_priority_order();
      obs_t o;
      logic [511:0] rd;
      logic [578:0] ef;
      int order [3] = '{1, 0, 2};
      imem_addr = rand_addr(); ptw_addr = rand_addr(); dmem_addr = rand_addr();
      dmem_wdata = rand_line(); dmem_we = 1'b1; dmem_is_amo = 1'b0; dmem_upgrade = 1'b1; dmem_amo_op = 5'h0;
      imem_req = 1'b1; dmem_req = 1'b1; ptw_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ef = exp_fields(order[k]);
         model_commit(imem_req, ptw_req, order[k]);
         rd = rand_line();
         model_ack(order[k], rd);
         do_l2(0, 0, rd, 1'b0, 1'b0, o);
         n_checks++; if (o.acks !== 3'(1 << order[k])) begin n_fail++; $display("FAIL prio_ack_%0d: got %b expected %b", k, o.acks, 3'(1 << order[k])); end
         n_checks++; if (o.fields !== ef) begin n_fail++; $display("FAIL prio_fields_%0d: got %h expected %h", k, o.fields, ef); end
         n_checks++; if (o.wait_cycles !== 1) begin n_fail++; $display("FAIL prio_grant_delay_%0d: got %0d expected 1", k, o.wait_cycles); end
         n_checks++; if ({o.idata, o.ddata, o.pdata} !== {exp_idata, exp_ddata, exp_pdata}) begin n_fail++; $display("FAIL prio_data_%0d: got pte %h expected pte %h", k, o.pdata, exp_pdata); end
      end
   endtask

   task automatic test_pte_extract();
      obs_t o;
      logic [511:0] line;
      logic [63:0] w [8];
      for (int j = 0; j < 8; j++) begin
         w[j] = {32'hFEED0000 + 32'(j), $urandom()};
         line[j*64 +: 64] = w[j];
      end
      ptw_addr = 56'h1000_0028;
      ptw_req = 1'b1;
      model_commit(0, 1, 2);
      do_l2(1, 2, line, 1'b0, 1'b0, o);
      n_checks++; if (o.acks !== 3'b100) begin n_fail++; $display("FAIL pte_ack_w5: got %b expected 100", o.acks); end
      n_checks++; if (o.pdata !== w[5]) begin n_fail++; $display("FAIL pte_w5: got %h expected %h", o.pdata, w[5]); end
      ptw_addr = 56'h1000_0038;
      ptw_req = 1'b1;
      model_commit(0, 1, 2);
      do_l2(0, 0, line, 1'b0, 1'b0, o);
      n_checks++; if (o.pdata !== w[7]) begin n_fail++; $display("FAIL pte_w7: got %h expected %h", o.pdata, w[7]); end
      exp_pdata = w[7];
   endtask

   task automatic test_starvation();
      obs_t o;
      logic [511:0] rd;
      logic [578:0] ef;
      int want;
      imem_addr = rand_addr(); dmem_addr = rand_addr(); dmem_we = 1'b0; dmem_upgrade = 1'b0;
      imem_req = 1'b1; dmem_req = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         want = (k == LIMIT + 1) ? 0 : 1;
         ef = exp_fields(want);
         model_commit(imem_req, ptw_req, want);
         rd = rand_line();
         model_ack(want, rd);
         do_l2(0, 0, rd, 1'b0, 1'b0, o);
         n_checks++; if (o.acks !== 3'(1 << want)) begin n_fail++; $display("FAIL starve_arb_%0d: got %b expected %b", k, o.acks, 3'(1 << want)); end
         n_checks++; if (o.fields !== ef) begin n_fail++; $display("FAIL starve_fields_%0d: got %h expected %h", k, o.fields, ef); end
         dmem_req = 1'b1;
         imem_req = 1'b1;
      end
      imem_req = 1'b0; dmem_req = 1'b0;
      step();
   endtask

   task automatic test_ready_stall();
      obs_t o;
      logic [511:0] rd;
      logic [578:0] ef;
      dmem_addr = rand_addr(); dmem_wdata = rand_line(); dmem_we = 1'b1;
      dmem_is_amo = 1'b1; dmem_amo_op = 5'h0B; dmem_upgrade = 1'b0;
      dmem_req = 1'b1;
      ef = exp_fields(1);
      model_commit(0, 0, 1);
      rd = rand_line();
      model_ack(1, rd);
      do_l2(20, 1, rd, 1'b0, 1'b1, o);
      n_checks++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b expected 1", o.stable); end
      n_checks++; if (o.fields !== ef) begin n_fail++; $display("FAIL stall_fields: got %h expected %h", o.fields, ef); end
      n_checks++; if (o.valid_after !== 1'b0) begin n_fail++; $display("FAIL stall_accept: got valid %b expected 0", o.valid_after); end
      n_checks++; if (o.lat !== 24) begin n_fail++; $display("FAIL stall_latency: got %0d expected 24", o.lat); end
      n_checks++; if (o.ddata !== rd) begin n_fail++; $display("FAIL stall_rdata: got %h expected %h", o.ddata, rd); end
   endtask

   task automatic test_reset_mid_wait();
      obs_t o;
      logic [511:0] rd;
      n_checks++; if (spurious_resp !== 1'b0) begin n_fail++; $display("FAIL spur_before: got %b expected 0", spurious_resp); end
      dmem_addr = rand_addr(); dmem_req = 1'b1;
      step();
      n_checks++; if (l2_req_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_req: got %b expected 1", l2_req_valid); end
      l2_req_ready = 1'b1;
      step();
      l2_req_ready = 1'b0;
      rst_n = 1'b0;
      dmem_req = 1'b0;
      step();
      rst_n = 1'b1;
      cnt_i_m = 0; cnt_p_m = 0; exp_idata = '0; exp_ddata = '0; exp_pdata = '0;
      step();
      l2_resp_valid = 1'b1;
      l2_resp_rdata = rand_line();
      step();
      l2_resp_valid = 1'b0;
      n_checks++; if ({imem_ack, dmem_ack, ptw_ack} !== 3'b000) begin n_fail++; $display("FAIL midrst_ack: got %b expected 000", {imem_ack, dmem_ack, ptw_ack}); end
      n_checks++; if (spurious_resp !== 1'b1) begin n_fail++; $display("FAIL midrst_spurious: got %b expected 1", spurious_resp); end
      step();
      n_checks++; if ({imem_ack, dmem_ack, ptw_ack, l2_req_valid} !== 4'b0) begin n_fail++; $display("FAIL midrst_idle: got %b expected 0000", {imem_ack, dmem_ack, ptw_ack, l2_req_valid}); end
      n_checks++; if (dmem_rdata !== 512'd0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", dmem_rdata); end
      dmem_addr = rand_addr(); dmem_we = 1'b0; dmem_is_amo = 1'b0; dmem_req = 1'b1;
      rd = rand_line();
      model_commit(0, 0, 1);
      model_ack(1, rd);
      do_l2(0, 0, rd, 1'b1, 1'b0, o);
      n_checks++; if (o.wait_cycles !== 1) begin n_fail++; $display("FAIL err_grant_delay: got %0d expected 1", o.wait_cycles); end
      n_checks++; if ({o.acks, o.err} !== 4'b0101) begin n_fail++; $display("FAIL err_ack: got %b expected 0101", {o.acks, o.err}); end
   endtask

   task automatic test_random();
      obs_t o;
      logic [511:0] rd;
      logic [578:0] ef;
      logic er;
      int s;
      for (int t = 0; t < 40; t++) begin
         if (!imem_req && $urandom_range(0, 1) == 1) begin imem_addr = rand_addr(); imem_req = 1'b1; end
         if (!ptw_req && $urandom_range(0, 1) == 1) begin ptw_addr = rand_addr(); ptw_req = 1'b1; end
         if (!dmem_req && $urandom_range(0, 2) == 1) begin
            dmem_addr = rand_addr(); dmem_wdata = rand_line(); dmem_we = 1'($urandom());
            dmem_is_amo = 1'($urandom()); dmem_amo_op = 5'($urandom()); dmem_upgrade = 1'($urandom());
            dmem_req = 1'b1;
         end
         if (!(imem_req | dmem_req | ptw_req)) begin imem_addr = rand_addr(); imem_req = 1'b1; end
         s = model_pick(imem_req, dmem_req, ptw_req);
         ef = exp_fields(s);
         model_commit(imem_req, ptw_req, s);
         rd = rand_line();
         er = 1'($urandom());
         model_ack(s, rd);
         do_l2($urandom_range(0, 3), $urandom_range(0, 3), rd, er, 1'b0, o);
         n_checks++; if (o.timeout !== 0) begin n_fail++; $display("FAIL rnd_timeout_%0d: got %0d expected 0", t, o.timeout); end
         n_checks++; if (o.acks !== 3'(1 << s)) begin n_fail++; $display("FAIL rnd_ack_%0d: got %b expected %b", t, o.acks, 3'(1 << s)); end
         n_checks++; if (o.fields !== ef) begin n_fail++; $display("FAIL rnd_fields_%0d: got %h expected %h", t, o.fields, ef); end
         n_checks++; if (o.err !== er) begin n_fail++; $display("FAIL rnd_err_%0d: got %b expected %b", t, o.err, er); end
         n_checks++; if (o.idata !== exp_idata || o.ddata !== exp_ddata) begin n_fail++; $display("FAIL rnd_line_%0d: got i=%h expected i=%h", t, o.idata[63:0], exp_idata[63:0]); end
         n_checks++; if (o.pdata !== exp_pdata) begin n_fail++; $display("FAIL rnd_pte_%0d: got %h expected %h", t, o.pdata, exp_pdata); end
         n_checks++; if ({o.early, o.ack_after} !== 2'b00) begin n_fail++; $display("FAIL rnd_pulse_%0d: got %b expected 00", t, {o.early, o.ack_after}); end
      end
   endtask

   initial begin
      test_reset();
      test_single_ifetch();
      test_priority_order();
      test_pte_extract();
      test_starvation();
      test_ready_stall();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
